// File: rtl/alu_seq_param.sv
// -----------------------------------------------------------------------------
// alu_seq_param
//   Registered, parametrised ALU with a valid/ready handshake on both sides.
//   Single-cycle ops (add/sub/not/and/or/xor/slt/eq) complete on the accept
//   edge. Shifts run one bit per EXEC cycle. Compile with ALU_MUL_EN defined to
//   add an iterative shift-add multiplier on mode 1011. Without it, 1011 is an
//   illegal code and no multiplier logic is built.
//
//   Ports
//     clk               rising-edge clock
//     rst               asynchronous active-high reset
//     input_valid       request present
//     output_in_ready   request can be accepted (high only in IDLE)
//     input_mode_select 4-bit operation code
//     input_a/input_b   operands (input_b[SHAMT_W-1:0] = shift amount)
//     output_valid      result available (high only in DONE)
//     input_out_ready   consumer takes the result
//     output_result     registered result
//     output_flags      {illegal, overflow, carry, negative, zero}
// -----------------------------------------------------------------------------
module alu_seq_param #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    output logic             output_in_ready,
    input  logic [3:0]       input_mode_select,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             output_valid,
    input  logic             input_out_ready,
    output logic [WIDTH-1:0] output_result,
    output logic [4:0]       output_flags
);

    // One extra bit so the counter can hold WIDTH (multiply) as well as
    // any shift amount.
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       op_reg;       // low mode bits select the iterative op
    logic [WIDTH-1:0] work_reg;     // shift value, or multiplier B for MUL
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] result_reg;
    logic [4:0]       flags_reg;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] opa_reg;      // multiplicand
    logic [WIDTH-1:0] hi_reg;       // upper half of the partial product
    logic [WIDTH:0]   mul_sum;
`endif

    function automatic logic [4:0] make_flags(input logic ill, input logic ovf,
                                              input logic cy,
                                              input logic [WIDTH-1:0] r);
        // Illegal results report only the illegal bit.
        return {ill, ovf, cy, r[WIDTH-1] & ~ill, (r == '0) & ~ill};
    endfunction

    // ------------------------------------------------------------------
    // Accept-edge datapath
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   sub_res;
    logic [WIDTH-1:0]   acc_result;
    logic               acc_carry;
    logic               acc_ovf;
    logic               acc_illegal;
    logic               acc_multi;
    logic [CNT_W-1:0]   acc_count;

    assign shamt   = input_b[SHAMT_W-1:0];
    assign add_ext = {1'b0, input_a} + {1'b0, input_b};
    assign sub_res = input_a - input_b;

    always_comb begin
        acc_result  = '0;
        acc_carry   = 1'b0;
        acc_ovf     = 1'b0;
        acc_illegal = 1'b0;
        acc_multi   = 1'b0;
        acc_count   = '0;
        case (input_mode_select)
            4'b0000: begin
                acc_result = add_ext[WIDTH-1:0];
                acc_carry  = add_ext[WIDTH];
                acc_ovf    = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                             (add_ext[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'b0001: begin
                acc_result = sub_res;
                acc_carry  = (input_a < input_b);
                acc_ovf    = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                             (sub_res[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'b0010: acc_result = ~input_a;
            4'b0011: acc_result = input_a & input_b;
            4'b0100: acc_result = input_a | input_b;
            4'b0101: acc_result = input_a ^ input_b;
            4'b0110: acc_result = {{(WIDTH-1){1'b0}},
                                   ($signed(input_a) < $signed(input_b))};
            4'b0111: acc_result = {{(WIDTH-1){1'b0}}, (input_a == input_b)};
            4'b1000, 4'b1001, 4'b1010: begin
                // A zero shift completes immediately with result = A.
                acc_result = input_a;
                acc_count  = CNT_W'(shamt);
                acc_multi  = (shamt != '0);
            end
`ifdef ALU_MUL_EN
            4'b1011: begin
                acc_multi = 1'b1;
                acc_count = CNT_W'(WIDTH);
            end
`endif
            default: acc_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // One EXEC iteration. step_out is the carry reported if this is the
    // final step: last bit shifted out, or "high half non-zero" for MUL.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] step_work;
    logic             step_out;
    logic             last_step;

    assign last_step = (count_reg == CNT_W'(1));

`ifdef ALU_MUL_EN
    assign mul_sum = {1'b0, hi_reg} + (work_reg[0] ? {1'b0, opa_reg} : '0);
`endif

    always_comb begin
        step_work = work_reg;
        step_out  = 1'b0;
        case (op_reg)
            2'b00: begin
                step_work = {work_reg[WIDTH-2:0], 1'b0};
                step_out  = work_reg[WIDTH-1];
            end
            2'b01: begin
                step_work = {1'b0, work_reg[WIDTH-1:1]};
                step_out  = work_reg[0];
            end
            2'b10: begin
                step_work = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
                step_out  = work_reg[0];
            end
            default: begin
`ifdef ALU_MUL_EN
                // Product {hi, lo} shifts right one bit per step; lo
                // starts as B and ends as the low half of A*B.
                step_work = {mul_sum[0], work_reg[WIDTH-1:1]};
                step_out  = |mul_sum[WIDTH:1];
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 2'b00;
            work_reg   <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
`ifdef ALU_MUL_EN
            opa_reg    <= '0;
            hi_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (input_valid) begin
                        op_reg    <= input_mode_select[1:0];
                        count_reg <= acc_count;
                        work_reg  <= input_a;
`ifdef ALU_MUL_EN
                        opa_reg   <= input_a;
                        hi_reg    <= '0;
                        if (input_mode_select == 4'b1011)
                            work_reg <= input_b;
`endif
                        if (acc_multi) begin
                            state_reg <= ST_EXEC;
                        end else begin
                            state_reg  <= ST_DONE;
                            result_reg <= acc_result;
                            flags_reg  <= make_flags(acc_illegal, acc_ovf,
                                                     acc_carry, acc_result);
                        end
                    end
                end
                ST_EXEC: begin
                    work_reg  <= step_work;
                    count_reg <= count_reg - CNT_W'(1);
`ifdef ALU_MUL_EN
                    hi_reg    <= mul_sum[WIDTH:1];
`endif
                    if (last_step) begin
                        state_reg  <= ST_DONE;
                        result_reg <= step_work;
                        flags_reg  <= make_flags(1'b0, 1'b0, step_out, step_work);
                    end
                end
                ST_DONE: begin
                    if (input_out_ready)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign output_in_ready = (state_reg == ST_IDLE);
    assign output_valid    = (state_reg == ST_DONE);
    assign output_result   = result_reg;
    assign output_flags    = flags_reg;

endmodule

// File: tb/tb_alu_seq_param.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_param
//   Directed and random checks of alu_seq_param (WIDTH=16) against a
//   behavioural model built from plain arithmetic. Latency is counted in
//   clock edges starting with the accept edge.
// -----------------------------------------------------------------------------
module tb_alu_seq_param;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         input_valid = 1'b0;
    logic         output_in_ready;
    logic [3:0]   input_mode_select = 4'd0;
    logic [W-1:0] input_a = '0;
    logic [W-1:0] input_b = '0;
    logic         output_valid;
    logic         input_out_ready = 1'b0;
    logic [W-1:0] output_result;
    logic [4:0]   output_flags;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .input_valid       (input_valid),
        .output_in_ready   (output_in_ready),
        .input_mode_select (input_mode_select),
        .input_a           (input_a),
        .input_b           (input_b),
        .output_valid      (output_valid),
        .input_out_ready   (input_out_ready),
        .output_result     (output_result),
        .output_flags      (output_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: result, flags {ill,ovf,cy,neg,zero} and latency.
    task automatic model(input logic [3:0] m, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] res,
                         output logic [4:0] flg, output int lat);
        int          n;
        int          sa, sb, sr;
        logic [31:0] wide;
        logic        cy, ov, ill;
        n   = int'(b[3:0]);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        cy  = 1'b0; ov = 1'b0; ill = 1'b0; lat = 1; res = '0;
        case (m)
            4'd0: begin
                wide = 32'(a) + 32'(b); res = wide[15:0]; cy = wide[16];
                sr = sa + sb; ov = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                res = a - b; cy = (a < b);
                sr = sa - sb; ov = (sr > 32767) || (sr < -32768);
            end
            4'd2: res = ~a;
            4'd3: res = a & b;
            4'd4: res = a | b;
            4'd5: res = a ^ b;
            4'd6: res = (sa < sb) ? 16'd1 : 16'd0;
            4'd7: res = (a == b) ? 16'd1 : 16'd0;
            4'd8: begin
                wide = 32'(a) << n; res = wide[15:0];
                cy = (n == 0) ? 1'b0 : wide[16];
                lat = n + 1;
            end
            4'd9: begin
                res = a >> n;
                cy = (n == 0) ? 1'b0 : ((a >> (n - 1)) & 16'd1) != 0;
                lat = n + 1;
            end
            4'd10: begin
                sr = sa >>> n; res = sr[15:0];
                cy = (n == 0) ? 1'b0 : (((sa >>> (n - 1)) & 1) != 0);
                lat = n + 1;
            end
`ifdef ALU_MUL_EN
            4'd11: begin
                wide = 32'(a) * 32'(b); res = wide[15:0];
                cy = (wide[31:16] != 0); lat = 17;
            end
`endif
            default: ill = 1'b1;
        endcase
        if (ill) flg = 5'b10000;
        else     flg = {1'b0, ov, cy, res[15], (res == 16'd0)};
    endtask

    // Issue one request starting #1 after a posedge with the DUT idle,
    // wait for the result, compare against the model. hold = cycles to
    // keep input_out_ready low once the result is up.
    task automatic run_op(input string tag, input logic [3:0] m,
                          input logic [15:0] a, input logic [15:0] b,
                          input int hold,
                          output logic [15:0] got_res,
                          output logic [4:0] got_flg, output int got_lat);
        logic [15:0] e_res;
        logic [4:0]  e_flg;
        int          e_lat;
        model(m, a, b, e_res, e_flg, e_lat);
        input_valid = 1'b1; input_mode_select = m; input_a = a; input_b = b;
        check({tag, ".in_ready"}, 32'(output_in_ready), 32'd1);
        @(posedge clk); #1;
        input_valid = 1'b0;
        check({tag, ".busy"}, 32'(output_in_ready), 32'd0);
        got_lat = 1;
        while (!output_valid && got_lat < 64) begin
            @(posedge clk); #1; got_lat++;
        end
        got_res = output_result;
        got_flg = output_flags;
        $display("op %s mode=%h a=%h b=%h -> res=%h flags=%b lat=%0d",
                 tag, m, a, b, got_res, got_flg, got_lat);
        check({tag, ".lat"},   32'(got_lat), 32'(e_lat));
        check({tag, ".res"},   32'(got_res), 32'(e_res));
        check({tag, ".flags"}, 32'(got_flg), 32'(e_flg));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        input_out_ready = 1'b1;
        @(posedge clk); #1;
        input_out_ready = 1'b0;
        check({tag, ".popped"}, 32'(output_valid), 32'd0);
    endtask

    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
    int          stale;

    initial begin
        // Reset state
        #2;
        check("rst.valid",  32'(output_valid),  32'd0);
        check("rst.result", 32'(output_result), 32'd0);
        check("rst.flags",  32'(output_flags),  32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("rst.in_ready", 32'(output_in_ready), 32'd1);

        // Add overflow
        run_op("add_ovf", 4'b0000, 16'h7FFF, 16'h0001, 0, r, f, lat);
        check("add_ovf.spec_res",   32'(r), 32'h8000);
        check("add_ovf.spec_flags", 32'(f), 32'b01010);
        check("add_ovf.spec_lat",   32'(lat), 32'd1);

        // Sub borrow
        run_op("sub_brw", 4'b0001, 16'h0003, 16'h0005, 0, r, f, lat);
        check("sub_brw.spec_res",   32'(r), 32'hFFFE);
        check("sub_brw.spec_flags", 32'(f), 32'b00110);

        // Backpressure: result held, second request ignored
        input_valid = 1'b1; input_mode_select = 4'b0111;
        input_a = 16'h1234; input_b = 16'h1234;
        @(posedge clk); #1;
        input_mode_select = 4'b0000; input_a = 16'h0101; input_b = 16'h0202;
        for (int i = 0; i < 5; i++) begin
            check("bp.valid",    32'(output_valid),    32'd1);
            check("bp.result",   32'(output_result),   32'h0001);
            check("bp.flags",    32'(output_flags),    32'd0);
            check("bp.in_ready", 32'(output_in_ready), 32'd0);
            $display("bp cycle %0d res=%h flags=%b", i, output_result, output_flags);
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        input_out_ready = 1'b1;
        @(posedge clk); #1;
        input_out_ready = 1'b0;
        check("bp.idle",     32'(output_in_ready), 32'd1);
        check("bp.no_second", 32'(output_result),  32'h0001);

        // Reset during EXEC of SLL n=9
        input_valid = 1'b1; input_mode_select = 4'b1000;
        input_a = 16'h00F3; input_b = 16'd9;
        @(posedge clk); #1;
        input_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst.valid",  32'(output_valid),  32'd0);
        check("midrst.result", 32'(output_result), 32'd0);
        check("midrst.flags",  32'(output_flags),  32'd0);
        #2 rst = 1'b0;
        #1;
        check("midrst.in_ready", 32'(output_in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (output_valid) stale++;
        end
        $display("midrst stale_valid_cycles=%0d", stale);
        check("midrst.no_stale", 32'(stale), 32'd0);

        // Shifts
        run_op("sra3", 4'b1010, 16'h8001, 16'h0003, 0, r, f, lat);
        check("sra3.spec_res", 32'(r), 32'hF000);
        check("sra3.spec_cy",  32'(f[2]), 32'd0);
        check("sra3.spec_lat", 32'(lat), 32'd4);
        run_op("srl0", 4'b1001, 16'hA5C3, 16'hFFF0, 0, r, f, lat);
        check("srl0.spec_res", 32'(r), 32'hA5C3);
        check("srl0.spec_lat", 32'(lat), 32'd1);

        // Multiply / illegal
        run_op("mul", 4'b1011, 16'h0100, 16'h0100, 0, r, f, lat);
`ifdef ALU_MUL_EN
        check("mul.spec_lat",   32'(lat), 32'd17);
        check("mul.spec_flags", 32'(f),   32'b00101);
`else
        check("mul.spec_lat",   32'(lat), 32'd1);
        check("mul.spec_flags", 32'(f),   32'b10000);
`endif
        check("mul.spec_res", 32'(r), 32'h0000);
        run_op("ill1100", 4'b1100, 16'hFFFF, 16'h0001, 1, r, f, lat);
        check("ill1100.spec_flags", 32'(f), 32'b10000);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                   16'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
                   r, f, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, registered successor to the 16-bit 8-function combinational ALU.
- Generic WIDTH; adds flag outputs and a valid/ready handshake on both sides.
- Adds multi-cycle iterative shifts and an optional shift-add multiplier, sequenced by an FSM.
- Sits between the decode/operand registers and the writeback register of the lab datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from input_b[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- input_valid  input  1  request present.
- output_in_ready  output  1  block can accept a request (high only in IDLE).
- input_mode_select  input  4  operation code.
- input_a  input  WIDTH  operand A.
- input_b  input  WIDTH  operand B / shift amount.
- output_valid  output  1  result available.
- input_out_ready  input  1  consumer accepts result.
- output_result  output  WIDTH  registered result.
- output_flags  output  5  {illegal, overflow, carry, negative, zero}.

Behaviour:
- Reset (async, any state): FSM→IDLE; output_valid=0; output_result=0; output_flags=0; output_in_ready=1 once reset deasserts.
- Accept occurs on a clock edge with input_valid && output_in_ready. Operands and mode are latched, and in_ready drops the next cycle.
- States:
  - IDLE → EXEC when the request is a multi-cycle op.
  - IDLE → DONE when the request is single-cycle.
  - EXEC → DONE when the iteration count reaches 0.
  - DONE → IDLE on input_out_ready.
- output_valid=1 exactly in DONE. Result and flags are stable while output_valid && !input_out_ready.
- Single-cycle ops (latency 1: valid the cycle after accept):
  - 0000 A+B, carry = carry-out.
  - 0001 A−B, carry = borrow (A<B unsigned).
  - 0010 ~A (bitwise).
  - 0011 A&B.
  - 0100 A|B.
  - 0101 A^B.
  - 0110 signed A<B, zero-extended to WIDTH.
  - 0111 A==B, zero-extended to WIDTH.
- Multi-cycle ops:
  - 1000 SLL, 1001 SRL, 1010 SRA: one bit per EXEC cycle; n = input_b[SHAMT_W-1:0].
  - Latency n+1 cycles. n=0 skips EXEC (latency 1, result=A).
  - carry = last bit shifted out (0 if n=0).
  - 1011 MUL (with ALU_MUL_EN only): see Optional Feature.
- Illegal codes (11xx, and 1011 without ALU_MUL_EN): latency 1, result=0, illegal=1, other flags=0.
- Flags:
  - zero = result==0.
  - negative = result[WIDTH-1].
  - overflow = signed overflow for 0000/0001, else 0.
  - carry = 0 for ops not listed above.
- Arithmetic is modulo 2^WIDTH; no saturation.
- input_valid while busy is ignored (no accept). Requester must hold the request until output_in_ready.
- Back-to-back: DONE→IDLE on the handshake edge. The next accept occurs at the earliest one cycle later.
- Reset mid-EXEC aborts the operation. No result is emitted.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - 1011 = unsigned shift-add multiply, low WIDTH bits of A*B.
  - WIDTH EXEC cycles, latency WIDTH+1.
  - carry = 1 if the high half of the full product is ≠0; overflow = 0.
- Undefined: 1011 is illegal as above. No multiplier datapath is synthesised.

Test Plan (WIDTH=16):
- Reset mid-operation: rst pulsed during EXEC of SLL n=9 → output_valid=0, result=0, flags=0, in_ready=1 after release; no stale result later.
- Add overflow: 0000, A=0x7FFF, B=0x0001 → one cycle later valid, result=0x8000, flags negative=1 overflow=1 carry=0 zero=0.
- Sub borrow: 0001, A=0x0003, B=0x0005 → result=0xFFFE, carry=1, negative=1.
- Backpressure: 0111, A=B=0x1234 → result=0x0001. Hold input_out_ready=0 for 5 cycles → result and flags stable, in_ready=0, a second request is not accepted.
- Shifts: SRA A=0x8001 n=3 → valid 4 cycles after accept, result=0xF000, carry=0. SRL n=0 → 1-cycle latency, result=A.
- Mul/illegal:
  - With ALU_MUL_EN: 1011, A=0x0100, B=0x0100 → valid 17 cycles after accept, result=0x0000, carry=1, zero=1.
  - Without ALU_MUL_EN: the same request → result=0, illegal=1, latency 1.
  - Either build: 1100 → illegal=1.
